// File: rtl/food_scheduler.sv
// food_scheduler: maze food grid with stall-free render lookup, eat/spawn write arbitration,
// food count and saturating score.
module food_scheduler #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int SPAWN_PERIOD = 1000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rd_cx,
    input  logic [3:0]  rd_cy,
    output logic [1:0]  rd_type,
    input  logic        eat_valid,
    input  logic [3:0]  eat_cx,
    input  logic [3:0]  eat_cy,
    output logic        eat_ready,
    output logic        eat_done,
    output logic [1:0]  eat_type,
    input  logic        spawn_en,
    output logic [7:0]  food_count,
    output logic [15:0] score
);
    localparam int TW = $clog2(SPAWN_PERIOD);
    localparam logic [4:0] GW = 5'(GRID_W);
    localparam logic [4:0] GH = 5'(GRID_H);
    typedef enum logic [1:0] {IDLE, EAT, SPAWN} state_t;
    state_t state, state_n;
    logic [1:0] grid [16][16];
    logic [TW-1:0] timer;
    logic [7:0] lfsr;
    logic spawn_pending, take_eat, take_spawn, expire, op_in, rd_in;
    logic [3:0] ocx, ocy;
    logic [1:0] t;
    logic [16:0] sum;
    always_comb begin
        eat_ready = state == IDLE;
        take_eat = eat_ready && eat_valid;
        take_spawn = eat_ready && !eat_valid && spawn_pending;
        state_n = take_eat ? EAT : take_spawn ? SPAWN : IDLE;
        expire = spawn_en && timer == TW'(SPAWN_PERIOD - 1);
        op_in = {1'b0, ocx} < GW && {1'b0, ocy} < GH;
        rd_in = {1'b0, rd_cx} < GW && {1'b0, rd_cy} < GH;
        t = op_in ? grid[ocy][ocx] : 2'd0;
        sum = {1'b0, score} + ((t == 2'd1) ? 17'd1 : 17'd10);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    grid[y][x] <= (x < GRID_W && y < GRID_H) ? 2'd1 : 2'd0;
            rd_type <= '0;
            eat_done <= 1'b0;
            eat_type <= '0;
            food_count <= 8'(GRID_W * GRID_H);
            score <= '0;
            state <= IDLE;
            timer <= '0;
            spawn_pending <= 1'b0;
            lfsr <= LFSR_SEED;
            ocx <= '0;
            ocy <= '0;
        end else begin
            rd_type <= rd_in ? grid[rd_cy][rd_cx] : 2'd0;
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (spawn_en) timer <= expire ? '0 : timer + 1'b1;
            // a fresh expiry wins over the clear so it is never lost
            spawn_pending <= expire | (spawn_pending & ~take_spawn);
            state <= state_n;
            if (take_eat) {ocx, ocy} <= {eat_cx, eat_cy};
            else if (take_spawn) {ocx, ocy} <= {lfsr[3:0], lfsr[7:4]};
            eat_done <= state == EAT;
            eat_type <= (state == EAT) ? t : 2'd0;
            if (state == EAT && t != 2'd0) begin
                grid[ocy][ocx] <= 2'd0;
                food_count <= food_count - 8'd1;
                score <= sum[16] ? 16'hFFFF : sum[15:0];
            end
            if (state == SPAWN && op_in && t == 2'd0) begin
                grid[ocy][ocx] <= 2'd2;
                food_count <= food_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_food_scheduler.sv
// tb_food_scheduler: directed stimulus with an eat_type scoreboard checked by a monitor.
module tb_food_scheduler;
    logic clk = 0, rst = 1;
    logic [3:0] rd_cx = 0, rd_cy = 0, eat_cx = 0, eat_cy = 0;
    logic eat_valid = 0, spawn_en = 0;
    logic [1:0] rd_type, eat_type;
    logic eat_ready, eat_done;
    logic [7:0] food_count;
    logic [15:0] score;
    int n_checks = 0, n_fail = 0, w;
    logic [1:0] exp_q [$];

    food_scheduler #(.GRID_W(16), .GRID_H(12), .SPAWN_PERIOD(4), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .rd_cx(rd_cx), .rd_cy(rd_cy), .rd_type(rd_type),
        .eat_valid(eat_valid), .eat_cx(eat_cx), .eat_cy(eat_cy), .eat_ready(eat_ready),
        .eat_done(eat_done), .eat_type(eat_type), .spawn_en(spawn_en),
        .food_count(food_count), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    always @(negedge clk) if (eat_done) begin
        if (exp_q.size() == 0) chk("eat_done_unexpected", 16'(eat_done), 16'd0);
        else chk("eat_type", 16'(eat_type), 16'(exp_q.pop_front()));
    end

    task automatic rd(input logic [3:0] x, input logic [3:0] y, input logic [1:0] e);
        @(negedge clk);
        rd_cx = x;
        rd_cy = y;
        @(negedge clk);
        chk("rd_type", 16'(rd_type), 16'(e));
    endtask

    task automatic do_eat(input logic [3:0] x, input logic [3:0] y, input logic [1:0] e,
                          output int waits);
        @(negedge clk);
        eat_cx = x;
        eat_cy = y;
        eat_valid = 1;
        waits = 0;
        while (!eat_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 eat_valid = 0;
        @(negedge clk);
        chk("eat_ready_busy", 16'(eat_ready), 16'd0);
        chk("eat_done_early", 16'(eat_done), 16'd0);
        @(negedge clk);
        chk("eat_done_pulse", 16'(eat_done), 16'd1);
        chk("eat_ready_back", 16'(eat_ready), 16'd1);
    endtask

    task automatic spawn_burst();
        @(negedge clk);
        spawn_en = 1;
        repeat (4) @(posedge clk);
        #1 spawn_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_count", 16'(food_count), 16'd192);
        chk("rst_score", score, 16'd0);
        chk("rst_ready", 16'(eat_ready), 16'd1);
        chk("rst_done", 16'(eat_done), 16'd0);
        chk("rst_rd", 16'(rd_type), 16'd0);
        rst = 0;
        rd(0, 0, 1);
        rd(15, 11, 1);
        do_eat(3, 4, 1, w);
        chk("eat1_count", 16'(food_count), 16'd191);
        chk("eat1_score", score, 16'd1);
        do_eat(3, 4, 0, w);
        chk("reeat_count", 16'(food_count), 16'd191);
        chk("reeat_score", score, 16'd1);
        rd(3, 4, 0);
        // spawn pending arrives just before an eat: eat must be taken first
        force dut.lfsr = 8'h43;
        spawn_burst();
        do_eat(5, 5, 1, w);
        chk("eat_beats_spawn_wait", 16'(w), 16'd0);
        chk("eat_beats_spawn_count", 16'(food_count), 16'd190);
        chk("eat_beats_spawn_score", score, 16'd2);
        repeat (3) @(negedge clk);
        chk("spawn_count", 16'(food_count), 16'd191);
        release dut.lfsr;
        rd(3, 4, 2);
        do_eat(3, 4, 2, w);
        chk("bonus_score", score, 16'd12);
        chk("bonus_count", 16'(food_count), 16'd190);
        rd(0, 12, 0);
        rd(5, 15, 0);
        do_eat(0, 12, 0, w);
        chk("oor_count", 16'(food_count), 16'd190);
        chk("oor_score", score, 16'd12);
        force dut.lfsr = 8'h43;
        spawn_burst();
        repeat (3) @(negedge clk);
        release dut.lfsr;
        chk("spawn2_count", 16'(food_count), 16'd191);
        force dut.score = 16'hFFFB;
        @(negedge clk);
        release dut.score;
        do_eat(3, 4, 2, w);
        chk("sat_score", score, 16'hFFFF);
        chk("sat_count", 16'(food_count), 16'd190);
        @(negedge clk);
        eat_cx = 1;
        eat_cy = 1;
        eat_valid = 1;
        @(posedge clk);
        #1 eat_valid = 0;
        rst = 1;
        #1;
        chk("midrst_count", 16'(food_count), 16'd192);
        chk("midrst_score", score, 16'd0);
        chk("midrst_done", 16'(eat_done), 16'd0);
        chk("midrst_type", 16'(eat_type), 16'd0);
        chk("midrst_rd", 16'(rd_type), 16'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("postrst_ready", 16'(eat_ready), 16'd1);
        chk("postrst_done", 16'(eat_done), 16'd0);
        rd(1, 1, 1);
        rd(3, 4, 1);
        rd(5, 5, 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
